prbs7_checker: RTL



---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs7_predictor.sv | 39 +++
 rtl/prbs7_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-7 receive checker: FSM states, sequence
// geometry, default lock/loss tuning and the next-bit helper.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int PRBS7_LEN       = 7;
  localparam int TAP_NEW         = 0;
  localparam int TAP_OLD         = 6;
  localparam int DEF_LOCK_COUNT  = 16;
  localparam int DEF_WINDOW      = 64;
  localparam int DEF_LOSS_THRESH = 8;

  // b[n] = b[n-1] ^ b[n-7], with hist[0] holding b[n-1].
  function automatic logic prbs7_next(input logic [PRBS7_LEN-1:0] hist);
    return hist[TAP_NEW] ^ hist[TAP_OLD];
  endfunction

endpackage

// File: rtl/prbs7_predictor.sv
// PRBS-7 history register and expected-bit predictor. Shifts either the
// received bit (acquisition) or its own prediction (free-running when locked).
module prbs7_predictor
  import prbs_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic shift_i,
  input  logic load_exp_i,
  input  logic rx_bit_i,
  output logic exp_o,
  output logic zero_o
);

  logic [PRBS7_LEN-1:0] hist_q;
  logic [PRBS7_LEN-1:0] hist_d;
  logic                 new_bit;

  assign exp_o  = prbs7_next(hist_q);
  assign zero_o = (hist_q == {PRBS7_LEN{1'b0}});

  always_comb begin
    new_bit = load_exp_i ? exp_o : rx_bit_i;
    if (shift_i) begin
      hist_d = {hist_q[PRBS7_LEN-2:0], new_bit};
    end else begin
      hist_d = hist_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= {PRBS7_LEN{1'b0}};
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// Serial PRBS-7 receive checker: self-synchronises, then counts compared bits
// and errors. Define PRBS_CHK_SATURATE_EN to make both counters saturate.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int unsigned BIT_W       = 32,
  parameter int unsigned ERR_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             control_i,
  input  logic             data_valid_i,
  input  logic             data_in_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_pulse_o,
  output logic             lock_lost_o,
  output logic [BIT_W-1:0] bit_count_o,
  output logic [ERR_W-1:0] err_count_o
);

  // match_cnt doubles as the fill counter, so it must reach PRBS7_LEN-1.
  localparam int MC_W = ($clog2(LOCK_COUNT + 1) > 3) ? $clog2(LOCK_COUNT + 1) : 3;
  localparam int WP_W = ($clog2(WINDOW) > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
`ifdef PRBS_CHK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  chk_state_e       state_q, state_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic [WP_W-1:0]  win_pos_q, win_pos_d;
  logic [WE_W-1:0]  win_err_q, win_err_d, win_err_new;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lock_lost_q, lock_lost_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept, shift, load_exp, exp_bit, hist_zero, mism;

  prbs7_predictor u_pred (
    .clock      (clock),
    .reset      (reset),
    .shift_i    (shift),
    .load_exp_i (load_exp),
    .rx_bit_i   (data_in_i),
    .exp_o      (exp_bit),
    .zero_o     (hist_zero)
  );

  assign accept      = control_i & data_valid_i;
  assign mism        = data_in_i ^ exp_bit;
  assign win_err_new = win_err_q + WE_W'(mism);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    win_pos_d   = win_pos_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    shift       = accept;
    load_exp    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_FILL: begin
          if (match_q == MC_W'(PRBS7_LEN - 1)) begin
            state_d = ST_SEARCH;
            match_d = '0;
          end else begin
            match_d = match_q + MC_W'(1);
          end
        end
        ST_SEARCH: begin
          if (!mism && !hist_zero) begin
            if (match_q == MC_W'(LOCK_COUNT - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              match_d   = '0;
              win_pos_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + MC_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          load_exp  = 1'b1;
          bit_cnt_d = (SAT && (&bit_cnt_q)) ? bit_cnt_q : bit_cnt_q + BIT_W'(1);
          if (mism) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = (SAT && (&err_cnt_q)) ? err_cnt_q : err_cnt_q + ERR_W'(1);
          end else begin
            err_pulse_d = 1'b0;
          end
          // Loss is judged before the window boundary so the last bit still counts.
          if (win_err_new == WE_W'(LOSS_THRESH)) begin
            state_d     = ST_SEARCH;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            match_d     = '0;
            win_pos_d   = '0;
            win_err_d   = '0;
          end else if (win_pos_q == WP_W'(WINDOW - 1)) begin
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            win_pos_d = win_pos_q + WP_W'(1);
            win_err_d = win_err_new;
          end
        end
        default: begin
          state_d  = ST_FILL;
          match_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (control_i && clear_i) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FILL;
      match_q     <= '0;
      win_pos_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      win_pos_q   <= win_pos_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked_o      = locked_q;
  assign error_pulse_o = err_pulse_q;
  assign lock_lost_o   = lock_lost_q;
  assign bit_count_o   = bit_cnt_q;
  assign err_count_o   = err_cnt_q;

endmodule
